// File: rtl/bmp_stream_loader.sv
// BMP byte-stream loader: accepts a file over valid/ready, writes it to the byte RAM
// and decodes header fields. Define BMP_HEADER_CHECK_EN to enforce signature and file-size checks.
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 70
`endif

module bmp_stream_loader #(
  parameter int BYTE_WIDTH = `BYTE_WIDTH,
  parameter int TOTAL_SIZE = `BMP_TOTAL_SIZE,
  parameter int ADDR_WIDTH = $clog2(TOTAL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  RAM_valid,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [BYTE_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           pix_offset,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height,
  output logic [15:0]           bpp
);

  localparam logic [31:0] HDR_LAST = 32'd53;

  typedef enum logic [2:0] {IDLE, HEADER, BODY, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [31:0] cnt;
  logic        accept;
  logic        hdr_bad;
  logic        last_byte;
  logic        restart;
  logic [7:0]  hb;

  assign byte_ready = (state == HEADER) || (state == BODY);
  assign busy       = byte_ready;
  assign done       = (state == DONE);
  assign accept     = byte_valid && byte_ready;
  assign restart    = (state != HEADER) && (state_next == HEADER);
  assign hb         = byte_data[7:0];

`ifdef BMP_HEADER_CHECK_EN
  logic [31:0] file_size;
  logic [31:0] size_now;

  // At count 5 the low three size bytes are already registered; splice in the top byte.
  assign size_now  = {hb, file_size[23:0]};
  assign hdr_bad   = ((cnt == 32'd0) && (hb != 8'h42)) ||
                     ((cnt == 32'd1) && (hb != 8'h4D)) ||
                     ((cnt == 32'd5) && ((size_now < 32'd54) || (size_now > 32'(TOTAL_SIZE))));
  assign last_byte = (cnt > 32'd5) && (cnt + 32'd1 == file_size);
  assign error     = (state == ERR);
`else
  assign hdr_bad   = 1'b0;
  assign last_byte = (cnt + 32'd1 == 32'(TOTAL_SIZE));
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:         if (start) state_next = HEADER;
      HEADER, BODY: begin
        if (accept) begin
          if (hdr_bad)                                state_next = ERR;
          else if (last_byte)                         state_next = DONE;
          else if (state == HEADER && cnt == HDR_LAST) state_next = BODY;
        end
      end
      DONE:         state_next = start ? HEADER : IDLE;
      ERR:          if (start) state_next = HEADER;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      RAM_valid  <= 1'b0;
      in_addr    <= '0;
      in_data    <= '0;
      pix_offset <= '0;
      img_width  <= '0;
      img_height <= '0;
      bpp        <= '0;
`ifdef BMP_HEADER_CHECK_EN
      file_size  <= '0;
`endif
    end else begin
      RAM_valid <= accept;
      if (restart) begin
        cnt        <= '0;
        pix_offset <= '0;
        img_width  <= '0;
        img_height <= '0;
        bpp        <= '0;
`ifdef BMP_HEADER_CHECK_EN
        file_size  <= '0;
`endif
      end else if (accept) begin
        in_addr <= cnt[ADDR_WIDTH-1:0];
        in_data <= byte_data;
        if (cnt != '1) cnt <= cnt + 32'd1;
        // Little-endian header fields, one byte lane per accepted offset.
        case (cnt)
`ifdef BMP_HEADER_CHECK_EN
          32'd2:  file_size[7:0]   <= hb;
          32'd3:  file_size[15:8]  <= hb;
          32'd4:  file_size[23:16] <= hb;
          32'd5:  file_size[31:24] <= hb;
`endif
          32'd10: pix_offset[7:0]   <= hb;
          32'd11: pix_offset[15:8]  <= hb;
          32'd12: pix_offset[23:16] <= hb;
          32'd13: pix_offset[31:24] <= hb;
          32'd18: img_width[7:0]    <= hb;
          32'd19: img_width[15:8]   <= hb;
          32'd20: img_width[23:16]  <= hb;
          32'd21: img_width[31:24]  <= hb;
          32'd22: img_height[7:0]   <= hb;
          32'd23: img_height[15:8]  <= hb;
          32'd24: img_height[23:16] <= hb;
          32'd25: img_height[31:24] <= hb;
          32'd28: bpp[7:0]          <= hb;
          32'd29: bpp[15:8]         <= hb;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bmp_stream_loader.sv
// Randomized bench for bmp_stream_loader: a byte-level file model predicts every
// output each cycle; literal checks pin the decoded header and write counts.
module tb_bmp_stream_loader;

  localparam int TS = 70;
  localparam int AW = $clog2(TS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, RAM_valid, busy, done, error;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic [31:0]   pix_offset, img_width, img_height;
  logic [15:0]   bpp;

  bmp_stream_loader #(.BYTE_WIDTH(8), .TOTAL_SIZE(TS)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .RAM_valid(RAM_valid), .in_addr(in_addr), .in_data(in_data),
    .busy(busy), .done(done), .error(error), .pix_offset(pix_offset),
    .img_width(img_width), .img_height(img_height), .bpp(bpp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus file and observed RAM image
  logic [7:0] file   [0:127];
  logic [7:0] shadow [0:127];
  int nwrites = 0;
  int ndone = 0;

  // Model: which bytes of the file have been taken since the last start/reset.
  bit         m_init = 0, m_load = 0, m_err = 0, m_done = 0, m_wv = 0;
  int         m_acc = 0, m_wa = 0;
  logic [7:0] m_wd = 8'h00;
  logic [7:0] m_b [0:127];

  function automatic logic [31:0] le(input int lo, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | 32'(m_b[lo + i]);
    return v;
  endfunction

  function automatic bit header_bad(input int i);
`ifdef BMP_HEADER_CHECK_EN
    if (i == 0) return m_b[0] != 8'h42;
    if (i == 1) return m_b[1] != 8'h4D;
    if (i == 5) return (le(2, 4) < 54) || (le(2, 4) > TS);
`endif
    return (i < 0);
  endfunction

  function automatic int expected_len();
`ifdef BMP_HEADER_CHECK_EN
    return (m_acc > 5) ? int'(le(2, 4)) : -1;
`else
    return TS;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 128; i++) m_b[i] = 8'h00;
    m_acc = 0;
  endtask

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic model_step();
    if (rst) begin
      m_init = 1; m_load = 0; m_err = 0; m_done = 0; m_wv = 0; m_wa = 0; m_wd = 8'h00;
      model_clear();
    end else if (m_init) begin
      m_done = 0;
      m_wv   = 0;
      if (m_load && byte_valid) begin
        m_wv = 1; m_wa = m_acc; m_wd = byte_data;
        m_b[m_acc] = byte_data;
        m_acc++;
        if (header_bad(m_acc - 1)) begin
          m_load = 0; m_err = 1;
        end else if (m_acc == expected_len()) begin
          m_load = 0; m_done = 1;
        end
      end else if (!m_load && start) begin
        m_load = 1; m_err = 0;
        model_clear();
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      check("byte_ready", 32'(byte_ready), 32'(m_load));
      check("busy", 32'(busy), 32'(m_load));
      check("done", 32'(done), 32'(m_done));
      check("error", 32'(error), 32'(m_err));
      check("RAM_valid", 32'(RAM_valid), 32'(m_wv));
      check("in_addr", 32'(in_addr), 32'(m_wa));
      check("in_data", 32'(in_data), 32'(m_wd));
      check("pix_offset", pix_offset, le(10, 4));
      check("img_width", img_width, le(18, 4));
      check("img_height", img_height, le(22, 4));
      check("bpp", 32'(bpp), le(28, 2));
      if (RAM_valid === 1'b1) begin
        nwrites++;
        shadow[in_addr] = in_data;
      end
      if (done === 1'b1) ndone++;
    end
    model_step();
  end

  task automatic build_file(input int size);
    for (int i = 0; i < 128; i++) file[i] = 8'($urandom_range(0, 255));
    for (int i = 2; i < 54; i++) file[i] = 8'h00;
    file[0] = 8'h42; file[1] = 8'h4D;
    file[2] = 8'(size); file[3] = 8'(size >> 8);
    file[10] = 8'd54; file[14] = 8'd40;
    file[18] = 8'd4; file[22] = 8'd2; file[26] = 8'd1; file[28] = 8'd16;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid held high, 1: toggling, 2: random gaps
  task automatic stream(input int n, input int mode, input int start_at, input int rst_at,
                        input int budget, input bit expect_stop);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < n && cyc < budget) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (cyc % 2 == 0);
        default: byte_valid = ($urandom_range(0, 3) != 0);
      endcase
      byte_data = file[idx];
      start = (idx == start_at);
      if (idx == rst_at) begin
        rst = 1'b1;
        byte_valid = 1'b0;
      end
      @(negedge clk);
      acc = byte_valid && (byte_ready === 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        return;
      end
      if (acc) idx++;
      cyc++;
    end
    byte_valid = 1'b0;
    if (!expect_stop) check("stream_budget", 32'(idx), 32'(n));
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_ram(input string name, input int n);
    int mism = 0;
    for (int i = 0; i < n; i++) if (shadow[i] !== file[i]) mism++;
    check(name, 32'(mism), 32'd0);
    check({name, "_writes"}, 32'(nwrites), 32'(n));
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 128; i++) shadow[i] = 8'hxx;
    nwrites = 0;
    ndone = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, 32'(byte_ready), 0);
    check({name, "_RAM_valid"}, 32'(RAM_valid), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_error"}, 32'(error), 0);
    check({name, "_in_addr"}, 32'(in_addr), 0);
    check({name, "_in_data"}, 32'(in_data), 0);
    check({name, "_hdr"}, pix_offset | img_width | img_height | 32'(bpp), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    // Valid 70-byte file, stream held valid.
    build_file(70);
    clear_obs();
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    stream(70, 0, -1, -1, 200, 0);
    settle();
    check("t1_width", img_width, 32'd4);
    check("t1_height", img_height, 32'd2);
    check("t1_bpp", 32'(bpp), 32'd16);
    check("t1_offset", pix_offset, 32'd54);
    check("t1_last_addr", 32'(in_addr), 32'd69);
    check("t1_done_pulses", 32'(ndone), 32'd1);
    check_ram("t1_ram", 70);

    // Same layout, new pixels, valid toggling every other cycle.
    build_file(70);
    clear_obs();
    pulse_start();
    stream(70, 1, -1, -1, 400, 0);
    settle();
    check_ram("t2_ram", 70);
    check("t2_done_pulses", 32'(ndone), 32'd1);

    // Random gaps with start pulsed mid-body: must be ignored.
    build_file(70);
    clear_obs();
    pulse_start();
    stream(70, 2, 60, -1, 600, 0);
    settle();
    check_ram("t3_ram", 70);
    check("t3_done_pulses", 32'(ndone), 32'd1);

    // Reset at byte 30, then a full reload from address 0.
    build_file(70);
    pulse_start();
    stream(70, 2, -1, 30, 600, 1);
    check_all_zero("midrst");
    clear_obs();
    pulse_start();
    stream(70, 0, -1, -1, 200, 0);
    settle();
    check_ram("t4_ram", 70);
    check("t4_width", img_width, 32'd4);

`ifdef BMP_HEADER_CHECK_EN
    // Bad second signature byte: two writes, then error holds.
    build_file(70);
    file[1] = 8'h4E;
    clear_obs();
    pulse_start();
    stream(70, 0, -1, -1, 20, 1);
    settle();
    check("t5_error", 32'(error), 32'd1);
    check("t5_ready", 32'(byte_ready), 32'd0);
    check("t5_writes", 32'(nwrites), 32'd2);
    file[1] = 8'h4D;
    clear_obs();
    pulse_start();
    check("t5_error_cleared", 32'(error), 32'd0);
    stream(70, 0, -1, -1, 200, 0);
    settle();
    check_ram("t5_reload_ram", 70);
    check("t5_reload_error", 32'(error), 32'd0);

    // File size one past RAM depth: stops after byte 5.
    build_file(TS + 1);
    clear_obs();
    pulse_start();
    stream(TS + 1, 0, -1, -1, 20, 1);
    settle();
    check("t6_error", 32'(error), 32'd1);
    check("t6_writes", 32'(nwrites), 32'd6);
    check("t6_last_addr", 32'(in_addr), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
